// File: rtl/tx_multibuf_master.sv
`default_nettype none
// ============================================================================
//  tx_multibuf_master : N-slot buffered serial transmit master with
//                       round-robin arbitration, ack timeout and bounded retry
//  Revision 1.0
// ============================================================================
module tx_multibuf_master #(
  parameter int DATA_W      = 32,
  parameter int NUM_BUF     = 4,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  TXIn,
  input  logic               StartTX,
  input  logic               Ackrecvd,
  output logic               TXout,
  output logic [NUM_BUF-1:0] TXBuffValid,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  cur_slot
);

  localparam int c_IW = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int c_BW = $clog2(DATA_W + 1);
  localparam int c_TW = $clog2(ACK_TIMEOUT + 1);
  localparam int c_RW = $clog2(MAX_RETRY + 2);

  localparam logic [ADDR_W:0] c_NBUF  = (ADDR_W+1)'(NUM_BUF);
  localparam logic [c_BW-1:0] c_BLAST = c_BW'(DATA_W - 1);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(ACK_TIMEOUT - 1);
  localparam logic [c_RW-1:0] c_RMAX  = c_RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_buf [NUM_BUF];
  logic [NUM_BUF-1:0]  r_valid;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_hold;
  logic [c_BW-1:0]     r_bitcnt;
  logic [c_TW-1:0]     r_tocnt;
  logic [c_RW-1:0]     r_retry;
  logic [ADDR_W-1:0]   r_ptr;

  logic                w_wr_ok;
  logic [c_IW-1:0]     w_waddr;
  logic [c_IW-1:0]     w_cur;
  logic [ADDR_W:0]     w_idx;
  logic [ADDR_W:0]     w_inc;
  logic [ADDR_W-1:0]   w_sel;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic                w_found;

  // The slot in flight is locked against host overwrites until it retires.
  assign w_wr_ok   = write && ({1'b0, addr} < c_NBUF) && !(busy && (addr == cur_slot));
  assign w_waddr   = addr[c_IW-1:0];
  assign w_cur     = cur_slot[c_IW-1:0];
  assign w_inc     = {1'b0, cur_slot} + 1'b1;
  assign w_ptr_nxt = (w_inc >= c_NBUF) ? '0 : w_inc[ADDR_W-1:0];

  // Round-robin scan: first valid slot at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      w_idx = {1'b0, r_ptr} + (ADDR_W+1)'(i);
      if (w_idx >= c_NBUF) w_idx = w_idx - c_NBUF;
      if (!w_found && r_valid[w_idx[c_IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_buf[w_waddr] <= TXIn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      TXout    <= 1'b1;
      r_valid  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cur_slot <= '0;
      r_ptr    <= '0;
      r_retry  <= '0;
      r_bitcnt <= '0;
      r_tocnt  <= '0;
      r_shift  <= '0;
      r_hold   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (w_wr_ok) r_valid[w_waddr] <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (StartTX && w_found) begin
            r_state  <= S_START;
            TXout    <= 1'b0;
            busy     <= 1'b1;
            cur_slot <= w_sel;
            r_shift  <= r_buf[w_sel[c_IW-1:0]];
            r_hold   <= r_buf[w_sel[c_IW-1:0]];
          end
        end
        S_START: begin
          r_state  <= S_DATA;
          TXout    <= r_shift[DATA_W-1];
          r_shift  <= r_shift << 1;
          r_bitcnt <= '0;
        end
        S_DATA: begin
          if (r_bitcnt == c_BLAST) begin
            r_state <= S_STOP;
            TXout   <= 1'b1;
          end else begin
            TXout    <= r_shift[DATA_W-1];
            r_shift  <= r_shift << 1;
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        S_STOP: begin
          r_state <= S_WAIT;
          r_tocnt <= '0;
        end
        S_WAIT: begin
          if (Ackrecvd) begin
            r_valid[w_cur] <= 1'b0;
            done           <= 1'b1;
            r_ptr          <= w_ptr_nxt;
            r_retry        <= '0;
            r_state        <= S_IDLE;
            busy           <= 1'b0;
          end else if (r_tocnt == c_TLAST) begin
            if (r_retry < c_RMAX) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_START;
              TXout   <= 1'b0;
              r_shift <= r_hold;
            end else begin
              r_valid[w_cur] <= 1'b0;
              err            <= 1'b1;
              r_ptr          <= w_ptr_nxt;
              r_retry        <= '0;
              r_state        <= S_IDLE;
              busy           <= 1'b0;
            end
          end else begin
            r_tocnt <= r_tocnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign TXBuffValid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_tx_multibuf_master.sv
`default_nettype none
// ============================================================================
//  tb_tx_multibuf_master : directed bench with a frame-position reference
//                          model checked every cycle plus literal expectations
//  Revision 1.0
// ============================================================================
module tb_tx_multibuf_master;

  localparam int DW = 8;
  localparam int NB = 4;
  localparam int AW = 4;
  localparam int TO = 4;
  localparam int MR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] TXIn = '0;
  logic          StartTX = 1'b0;
  logic          Ackrecvd = 1'b0;
  logic          TXout;
  logic [NB-1:0] TXBuffValid;
  logic          busy, done, err;
  logic [AW-1:0] cur_slot;

  tx_multibuf_master #(
    .DATA_W(DW), .NUM_BUF(NB), .ADDR_W(AW), .ACK_TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .write(write), .addr(addr), .TXIn(TXIn),
    .StartTX(StartTX), .Ackrecvd(Ackrecvd), .TXout(TXout),
    .TXBuffValid(TXBuffValid), .busy(busy), .done(done), .err(err),
    .cur_slot(cur_slot)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int ack_on = 0;

  // Reference model: one frame-position counter instead of named states.
  // pos 0 = start bit, 1..DW = data MSB first, DW+1 = stop, >= DW+2 = waiting.
  logic [NB-1:0] m_valid;
  logic [DW-1:0] m_data [NB];
  logic [DW-1:0] od [NB];
  logic [NB-1:0] ov;
  logic [1:0]    m_ptr, m_slot, idx2, sel, a2;
  logic [DW-1:0] m_held;
  bit            m_busy, m_done, m_err, fnd;
  int            m_pos, m_retry;

  function automatic logic exp_tx();
    logic [DW-1:0] t;
    if (!m_busy || m_pos > DW) return 1'b1;
    if (m_pos == 0) return 1'b0;
    t = m_held >> (DW - m_pos);
    return t[0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = '0; m_ptr = '0; m_slot = '0; m_busy = 0; m_pos = 0;
      m_retry = 0; m_done = 0; m_err = 0; m_held = '0;
    end else begin
      ov = m_valid;
      od = m_data;
      m_done = 0;
      m_err  = 0;
      if (write && addr < NB) begin
        a2 = addr[1:0];
        if (!(m_busy && a2 == m_slot)) begin
          m_data[a2]  = TXIn;
          m_valid[a2] = 1'b1;
        end
      end
      if (!m_busy) begin
        if (StartTX && ov != '0) begin
          fnd = 0;
          sel = '0;
          for (int i = 0; i < NB; i++) begin
            idx2 = 2'((int'(m_ptr) + i) % NB);
            if (!fnd && ov[idx2]) begin fnd = 1; sel = idx2; end
          end
          m_slot = sel; m_held = od[sel]; m_busy = 1; m_pos = 0;
        end
      end else if (m_pos >= DW + 2 &&
                   (Ackrecvd || (m_pos == DW + 2 + TO - 1 && m_retry == MR))) begin
        m_valid[m_slot] = 1'b0;
        m_ptr   = 2'((int'(m_slot) + 1) % NB);
        m_retry = 0;
        m_busy  = 0;
        if (Ackrecvd) m_done = 1; else m_err = 1;
      end else if (m_pos == DW + 2 + TO - 1) begin
        m_retry++;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  end

  // Receiver: acknowledge on the ack_on-th wait cycle (0 = never).
  always @(posedge clk) begin
    #1;
    Ackrecvd = (ack_on > 0) && m_busy && (m_pos == DW + 2 + ack_on - 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({TXout, TXBuffValid, busy, done, err, cur_slot} !==
          {exp_tx(), m_valid, m_busy, m_done, m_err, 2'b00, m_slot}) begin
        n_err++;
        $display("FAIL model t=%0t: got tx=%b v=%b busy=%b done=%b err=%b slot=%0d; need tx=%b v=%b busy=%b done=%b err=%b slot=%0d",
                 $time, TXout, TXBuffValid, busy, done, err, cur_slot,
                 exp_tx(), m_valid, m_busy, m_done, m_err, m_slot);
      end
    end
  end

  // Observers of the DUT for the literal checks.
  typedef struct packed { logic [AW-1:0] slot; logic [9:0] bits; } frame_t;
  frame_t fr_q[$];
  logic   st_q[$];
  frame_t cur_fr;
  int     fcnt = 0;
  bit     fcap = 0, prev_busy = 0, cap_stream = 0;
  int     done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (cap_stream && busy === 1'b1) st_q.push_back(TXout);
    if (busy !== 1'b1) fcap = 0;
    else if (!prev_busy) begin
      fcap = 1; fcnt = 0; cur_fr.slot = cur_slot; cur_fr.bits = '0;
    end
    if (fcap) begin
      cur_fr.bits[9 - fcnt] = TXout;
      fcnt++;
      if (fcnt == 10) begin fr_q.push_back(cur_fr); fcap = 0; end
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    write = 1'b1; addr = AW'(a); TXIn = d;
    tick();
    write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    fr_q.delete(); st_q.delete(); done_cnt = 0; err_cnt = 0;
  endtask

  task automatic wait_frames(input int n, input int max);
    int k = 0;
    while (!(fr_q.size() >= n && busy === 1'b0) && k < max) begin tick(); k++; end
    if (k >= max) begin
      n_vec++; n_err++;
      $display("FAIL wait_frames: got %0d frames busy=%b, need %0d idle", fr_q.size(), busy, n);
    end
    tick(); tick();
  endtask

  task automatic wait_busy(input int max);
    int k = 0;
    while (busy !== 1'b1 && k < max) begin tick(); k++; end
    if (k >= max) begin
      n_vec++; n_err++;
      $display("FAIL wait_busy: got busy=%b, need 1", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [41:0] exp_st, act_st;
    logic [13:0] att;
    tick();
    chk_en = 1'b1;
    do_reset();

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle%0d", i), {TXout, TXBuffValid, busy}, {1'b1, 4'b0000, 1'b0});
      tick();
    end

    // Single word 0xA5 in slot 2, ack on 3rd wait cycle
    wr(2, 8'hA5);
    ack_on = 3;
    StartTX = 1'b1;
    wait_frames(1, 100);
    StartTX = 1'b0;
    check("A5 frame bits", fr_q[0].bits, 10'b0101001011);
    check("A5 slot", fr_q[0].slot, 2);
    check("A5 done count", done_cnt, 1);
    check("A5 valid", TXBuffValid, 4'b0000);

    // Pointer now 3: slot 3 goes before slot 0
    fr_q.delete();
    wr(0, 8'h01); wr(3, 8'h03);
    StartTX = 1'b1;
    wait_frames(2, 200);
    StartTX = 1'b0;
    check("ptr3 first", fr_q[0].slot, 3);
    check("ptr3 second", fr_q[1].slot, 0);

    // Four slots, in-order service, immediate ack
    do_reset();
    ack_on = 1;
    for (int i = 0; i < 4; i++) wr(i, 8'(8'h11 * (i + 1)));
    StartTX = 1'b1;
    wait_frames(4, 400);
    StartTX = 1'b0;
    check("fill4 frames", fr_q.size(), 4);
    check("fill4 done count", done_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill4 slot%0d", i), fr_q[i].slot, i);
      check($sformatf("fill4 data%0d", i), fr_q[i].bits[8:1], 8'h11 * (i + 1));
    end

    // ptr=2 with slots 0 and 3 valid, ack on last allowed wait cycle
    do_reset();
    ack_on = TO;
    wr(1, 8'h55);
    StartTX = 1'b1;
    wait_frames(1, 100);
    StartTX = 1'b0;
    wr(0, 8'h0F); wr(3, 8'hF0);
    StartTX = 1'b1;
    wait_frames(3, 300);
    StartTX = 1'b0;
    check("ptr2 slot A", fr_q[1].slot, 3);
    check("ptr2 data A", fr_q[1].bits[8:1], 8'hF0);
    check("ptr2 slot B", fr_q[2].slot, 0);
    check("ptr2 data B", fr_q[2].bits[8:1], 8'h0F);

    // No ack: 1 + MAX_RETRY identical frames, then err and drop
    do_reset();
    ack_on = 0;
    wr(1, 8'hC3);
    cap_stream = 1'b1;
    StartTX = 1'b1;
    wait_frames(1, 300);
    StartTX = 1'b0;
    cap_stream = 1'b0;
    att = 14'b0_11000011_1_1111;
    exp_st = {att, att, att};
    act_st = '0;
    for (int i = 0; i < st_q.size() && i < 42; i++) act_st[41 - i] = st_q[i];
    check("retry busy cycles", st_q.size(), 42);
    check("retry stream", act_st, exp_st);
    check("retry err count", err_cnt, 1);
    check("retry done count", done_cnt, 0);
    check("retry valid", TXBuffValid, 4'b0000);

    // Locked-slot write ignored, other slot written; StartTX drop mid-frame
    do_reset();
    ack_on = 2;
    wr(1, 8'h5A);
    StartTX = 1'b1;
    wait_busy(20);
    StartTX = 1'b0;
    wr(1, 8'h77);
    wr(2, 8'h99);
    wait_frames(1, 100);
    check("lock data", fr_q[0].bits[8:1], 8'h5A);
    check("lock valid", TXBuffValid, 4'b0100);
    for (int i = 0; i < 5; i++) tick();
    check("hold idle busy", busy, 1'b0);

    // Reset during data bit 3 of the next frame
    StartTX = 1'b1;
    wait_busy(20);
    check("second slot", cur_slot, 2);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst outputs", {TXout, TXBuffValid, busy, done, err, cur_slot},
          {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0});
    StartTX = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
